// File: rtl/mux_rr_arbiter_if.sv
// Bundle of the two requester ports, the downstream valid/ready port and the mux select.
// The master side is the arbiter; the slave side is the surrounding producers/consumer.
interface mux_rr_arbiter_if #(
   parameter int SIZE = 2
);
   logic            req_a;
   logic [SIZE-1:0] a;
   logic            last_a;
   logic            req_b;
   logic [SIZE-1:0] b;
   logic            last_b;
   logic            ready;
   logic            gnt_a;
   logic            gnt_b;
   logic            c;
   logic [SIZE-1:0] z;
   logic            valid;

   modport master (
      input  req_a, a, last_a, req_b, b, last_b, ready,
      output gnt_a, gnt_b, c, z, valid
   );

   modport slave (
      output req_a, a, last_a, req_b, b, last_b, ready,
      input  gnt_a, gnt_b, c, z, valid
   );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 data mux onto one valid/ready port.
// Grants are bursts bounded by last_x or MAX_BURST beats; ties go to the requester that did not win last.
module mux_rr_arbiter #(
   parameter int SIZE      = 2,
   parameter int MAX_BURST = 4,
   parameter int CW        = 3
) (
   input  logic                clk,
   input  logic                reset,
   mux_rr_arbiter_if.master    bus,
   output logic [1:0]          dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            gnt_a_q, gnt_b_q, c_q;
   logic [CW-1:0]   count_q, count_d;
   logic            lw_q, lw_d;        // last winner: 0 = A, 1 = B
   logic            valid;
   logic            accept;
   logic            own_req;
   logic            own_last;
   logic            at_max;
   logic            grant_exit;

   function automatic state_e arb(input logic ra, input logic rb, input logic lw);
      state_e r;
      r = IDLE;
      if (ra && rb)  r = lw ? GRANT_A : GRANT_B;
      else if (ra)   r = GRANT_A;
      else if (rb)   r = GRANT_B;
      return r;
   endfunction

   // Handshake: a beat transfers on a cycle where valid && ready are both high.
   // valid depends only on the registered grants and the owner's req, never on ready.
   always_comb begin
      valid      = (gnt_a_q && bus.req_a) || (gnt_b_q && bus.req_b);
      accept     = valid && bus.ready;
      own_req    = gnt_b_q ? bus.req_b  : bus.req_a;
      own_last   = gnt_b_q ? bus.last_b : bus.last_a;
      at_max     = (count_q == CW'(MAX_BURST - 1));
      grant_exit = (state_q != IDLE) && (!own_req || (accept && (own_last || at_max)));
      lw_d       = grant_exit ? (state_q == GRANT_B) : lw_q;
      state_d    = state_q;
      if (state_q == IDLE || grant_exit)
         state_d = arb(bus.req_a, bus.req_b, lw_d);
      count_d = count_q;
      if (state_q == IDLE || grant_exit)
         count_d = '0;
      else if (accept)
         count_d = count_q + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         c_q     <= 1'b0;
         count_q <= '0;
         lw_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         gnt_a_q <= (state_d == GRANT_A);
         gnt_b_q <= (state_d == GRANT_B);
         count_q <= count_d;
         lw_q    <= lw_d;
         // select only moves when a grant is (re)entered, so IDLE keeps the last path
         if (state_d != IDLE)
            c_q <= (state_d == GRANT_B);
      end
   end

   assign bus.gnt_a   = gnt_a_q;
   assign bus.gnt_b   = gnt_b_q;
   assign bus.c       = c_q;
   assign bus.z       = c_q ? bus.b : bus.a;
   assign bus.valid   = valid;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random bursts, checked cycle by cycle
// against a behavioural model and a beat scoreboard.
module tb_mux_rr_arbiter;
  localparam int SIZE      = 2;
  localparam int MAX_BURST = 4;
  localparam int CW        = 3;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            req_a, last_a, req_b, last_b, ready;
  logic [SIZE-1:0] a, b;
  logic [1:0]      dbg_state;

  mux_rr_arbiter_if #(.SIZE(SIZE)) bus();
  assign bus.req_a  = req_a;
  assign bus.a      = a;
  assign bus.last_a = last_a;
  assign bus.req_b  = req_b;
  assign bus.b      = b;
  assign bus.last_b = last_b;
  assign bus.ready  = ready;

  mux_rr_arbiter #(.SIZE(SIZE), .MAX_BURST(MAX_BURST), .CW(CW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // bookkeeping
  int n_checks = 0;
  int n_fail   = 0;
  int sent_a = 0, sent_b = 0, got_a = 0, got_b = 0;
  logic [SIZE:0] exp_q[$];
  int obs_src[$];

  // behavioural model: owner 0 none, 1 A, 2 B
  int   m_owner, m_beats, m_lw;
  logic m_c;
  bit   acc_a, acc_b;
  int   rem_a, rem_b, cnt_a, cnt_b;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int arb(input bit ra, input bit rb, input int lw);
    if (ra && rb) return (lw == 1) ? 2 : 1;
    if (ra) return 1;
    if (rb) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_beats = 0; m_lw = 2; m_c = 1'b0;
    acc_a = 0; acc_b = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_a = 0; last_a = 0; a = '0; req_b = 0; last_b = 0; b = '0; ready = 0;
    rem_a = 0; rem_b = 0; cnt_a = 0; cnt_b = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  // one clock: check outputs mid-cycle, score beats, advance the model across the edge
  task automatic step();
    bit            ev, acc, ex, rq, lst;
    int            nxt;
    logic [SIZE:0] e;
    ex = 0;
    @(negedge clk);
    ev = (m_owner == 1 && req_a) || (m_owner == 2 && req_b);
    check_eq("gnt_a", bus.gnt_a, m_owner == 1);
    check_eq("gnt_b", bus.gnt_b, m_owner == 2);
    check_eq("c", bus.c, m_c);
    check_eq("valid", bus.valid, ev);
    check_eq("z", bus.z, m_c ? b : a);
    acc   = ev && ready;
    acc_a = acc && (m_owner == 1);
    acc_b = acc && (m_owner == 2);
    if (acc) begin
      exp_q.push_back({m_owner == 2, (m_owner == 2) ? b : a});
      if (m_owner == 1) sent_a++; else sent_b++;
    end
    if (bus.valid && ready) begin
      if (exp_q.size() == 0) check_eq("extra_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        check_eq("beat", {bus.gnt_b, bus.z}, e);
      end
      if (bus.gnt_a) got_a++; else if (bus.gnt_b) got_b++;
      obs_src.push_back(bus.gnt_b ? 1 : 0);
    end
    if (m_owner == 0) nxt = arb(req_a, req_b, m_lw);
    else begin
      rq  = (m_owner == 1) ? req_a : req_b;
      lst = (m_owner == 1) ? last_a : last_b;
      ex  = !rq || (acc && (lst || (m_beats + 1 == MAX_BURST)));
      if (ex) begin
        m_lw = m_owner;
        nxt  = arb(req_a, req_b, m_lw);
      end else nxt = m_owner;
    end
    if (m_owner == 0 || ex) m_beats = 0;
    else if (acc) m_beats++;
    @(posedge clk); #1;
    m_owner = nxt;
    if (nxt != 0) m_c = (nxt == 2);
  endtask

  // directed producer: len beats per burst (len 0 = never last), data changes per beat
  task automatic dir_prod(input bit acc, input int len, inout int cnt, inout logic rq,
                          inout logic lst, inout logic [SIZE-1:0] d);
    if (acc) begin
      cnt++;
      d = SIZE'($urandom);
      if (len != 0 && cnt == len - 1) lst = 1'b1;
      if (len != 0 && cnt == len) begin rq = 1'b0; lst = 1'b0; end
    end
  endtask

  // random producer: bursts of 1..6 beats, occasional early drop after an accepted beat
  task automatic rnd_prod(input bit acc, inout int rem, inout logic rq,
                          inout logic lst, inout logic [SIZE-1:0] d);
    if (acc) begin
      rem--;
      if (rem <= 0 || $urandom_range(0, 11) == 0) begin
        rq = 1'b0; lst = 1'b0; rem = 0;
      end else begin
        d = SIZE'($urandom);
        lst = (rem == 1);
      end
    end
    if (!rq && $urandom_range(0, 2) == 0) begin
      rem = $urandom_range(1, 6);
      rq  = 1'b1;
      d   = SIZE'($urandom);
      lst = (rem == 1);
    end
  endtask

  logic [SIZE-1:0] z0;

  initial begin
    reset = 1'b1;
    req_a = 0; last_a = 0; a = '0; req_b = 0; last_b = 0; b = '0; ready = 0;
    model_reset();
    @(negedge clk);
    check_eq("rst_gnt_a", bus.gnt_a, 0);
    check_eq("rst_gnt_b", bus.gnt_b, 0);
    check_eq("rst_c", bus.c, 0);
    check_eq("rst_valid", bus.valid, 0);
    do_reset();

    // single A burst of 3 beats, data 2'b10
    req_a = 1; a = 2'b10; ready = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 1) check_eq("t2_z", bus.z, 2'b10);
      if (acc_a) begin
        cnt_a++;
        if (cnt_a == 2) last_a = 1;
        if (cnt_a == 3) begin req_a = 0; last_a = 0; end
      end
    end
    check_eq("t2_beats", cnt_a, 3);

    // tie after reset: A first, then B with no bubble
    do_reset();
    req_a = 1; req_b = 1; ready = 1; a = SIZE'($urandom); b = SIZE'($urandom);
    for (int i = 0; i < 10; i++) begin
      step();
      dir_prod(acc_a, 2, cnt_a, req_a, last_a, a);
      dir_prod(acc_b, 2, cnt_b, req_b, last_b, b);
    end
    check_eq("t3_a", cnt_a, 2);
    check_eq("t3_b", cnt_b, 2);

    // both held without last: bursts capped at MAX_BURST, alternating
    do_reset();
    obs_src.delete();
    req_a = 1; req_b = 1; ready = 1;
    for (int i = 0; i < 18; i++) begin
      step();
      dir_prod(acc_a, 0, cnt_a, req_a, last_a, a);
      dir_prod(acc_b, 0, cnt_b, req_b, last_b, b);
    end
    check_eq("t4_len", obs_src.size() >= 16, 1);
    for (int i = 0; i < 16 && i < obs_src.size(); i++)
      check_eq("t4_src", obs_src[i], (i / MAX_BURST) % 2);

    // stall during GRANT_A
    do_reset();
    req_a = 1; ready = 1; a = 2'b01;
    step(); step();
    dir_prod(acc_a, 0, cnt_a, req_a, last_a, a);
    ready = 0;
    z0 = a;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t5_valid", bus.valid, 1);
      check_eq("t5_z_hold", bus.z, z0);
    end
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      dir_prod(acc_a, 0, cnt_a, req_a, last_a, a);
    end
    check_eq("t5_beats", cnt_a, 5);
    req_a = 0;
    step(); step();

    // asynchronous reset mid-cycle while B owns the mux
    do_reset();
    req_b = 1; ready = 1;
    step(); step();
    check_eq("t1_pre_gnt_b", bus.gnt_b, 1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check_eq("t1_gnt_a", bus.gnt_a, 0);
    check_eq("t1_gnt_b", bus.gnt_b, 0);
    check_eq("t1_c", bus.c, 0);
    check_eq("t1_valid", bus.valid, 0);
    do_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rnd_prod(acc_a, rem_a, req_a, last_a, a);
      rnd_prod(acc_b, rem_b, req_b, last_b, b);
      ready = ($urandom_range(0, 3) != 0);
    end
    req_a = 0; req_b = 0; last_a = 0; last_b = 0;
    for (int i = 0; i < 4; i++) step();

    check_eq("sb_a", got_a, sent_a);
    check_eq("sb_b", got_b, sent_b);
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("sb_idle", dbg_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
